// File: rtl/regfile_write_arbiter.sv
// Write-port owner for a small register file: clears every entry after reset,
// then shares the single write port between two requesters in round-robin order.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 2,
  parameter int NUM_REGISTERS = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     request_valid_0,
  input  logic [ADDRESS_WIDTH-1:0] request_register_0,
  input  logic [DATA_WIDTH-1:0]    request_data_0,
  output logic                     request_ready_0,
  input  logic                     request_valid_1,
  input  logic [ADDRESS_WIDTH-1:0] request_register_1,
  input  logic [DATA_WIDTH-1:0]    request_data_1,
  output logic                     request_ready_1,
  output logic                     init_done,
  output logic [ADDRESS_WIDTH-1:0] write_register,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     write_enable
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = ADDRESS_WIDTH'(NUM_REGISTERS - 1);

  logic [0:0]               state;
  logic [ADDRESS_WIDTH-1:0] init_index;
  logic                     pointer;
  logic                     grant_0;
  logic                     grant_1;

  logic                     vld_p1;
  logic [ADDRESS_WIDTH-1:0] wr_reg_p1;
  logic [DATA_WIDTH-1:0]    wr_data_p1;
  logic                     init_done_p1;

  // Returns {grant_1, grant_0}; the pointer only breaks ties.
  function automatic logic [1:0] arbitrate(input logic v0, input logic v1, input logic ptr);
    logic [1:0] g;
    g = 2'b00;
    if (v0 && v1) begin
      g = ptr ? 2'b10 : 2'b01;
    end else begin
      g = {v1, v0};
    end
    return g;
  endfunction

  // Stage p0: grant decode from current state and requester valids.
  always_comb begin
    {grant_1, grant_0} = 2'b00;
    if (state == ST_RUN) begin
      {grant_1, grant_0} = arbitrate(request_valid_0, request_valid_1, pointer);
    end
  end

  assign request_ready_0 = grant_0;
  assign request_ready_1 = grant_1;

  // Stage p1: registered write port toward the register file.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_INIT;
      init_index   <= '0;
      pointer      <= 1'b0;
      vld_p1       <= 1'b0;
      wr_reg_p1    <= '0;
      wr_data_p1   <= '0;
      init_done_p1 <= 1'b0;
    end else if (state == ST_INIT) begin
      vld_p1     <= 1'b1;
      wr_reg_p1  <= init_index;
      wr_data_p1 <= '0;
      init_index <= init_index + ADDRESS_WIDTH'(1);
      if (init_index == LAST_INDEX) begin
        state        <= ST_RUN;
        init_done_p1 <= 1'b1;
      end
    end else begin
      if (grant_0) begin
        vld_p1     <= 1'b1;
        wr_reg_p1  <= request_register_0;
        wr_data_p1 <= request_data_0;
        pointer    <= 1'b1;
      end else if (grant_1) begin
        vld_p1     <= 1'b1;
        wr_reg_p1  <= request_register_1;
        wr_data_p1 <= request_data_1;
        pointer    <= 1'b0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign write_enable   = vld_p1;
  assign write_register = wr_reg_p1;
  assign write_data     = wr_data_p1;
  assign init_done      = init_done_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized bench for regfile_write_arbiter against a
// transaction-level reference of the init sequence and round-robin grants.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        reset_n;
  logic        request_valid_0;
  logic [1:0]  request_register_0;
  logic [31:0] request_data_0;
  logic        request_ready_0;
  logic        request_valid_1;
  logic [1:0]  request_register_1;
  logic [31:0] request_data_1;
  logic        request_ready_1;
  logic        init_done;
  logic [1:0]  write_register;
  logic [31:0] write_data;
  logic        write_enable;

  regfile_write_arbiter #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(2), .NUM_REGISTERS(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .request_valid_0(request_valid_0), .request_register_0(request_register_0),
    .request_data_0(request_data_0), .request_ready_0(request_ready_0),
    .request_valid_1(request_valid_1), .request_register_1(request_register_1),
    .request_data_1(request_data_1), .request_ready_1(request_ready_1),
    .init_done(init_done), .write_register(write_register),
    .write_data(write_data), .write_enable(write_enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Reference: init progress, tie-break preference, last written values, register contents.
  bit          m_init;
  int          m_init_count;
  int          m_pref;
  bit          m_done;
  logic [1:0]  m_last_reg;
  logic [31:0] m_last_data;
  logic [31:0] exp_rf [4];
  logic [31:0] dut_rf [4];
  bit          acc0, acc1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_init_count = 0; m_pref = 0; m_done = 0;
    m_last_reg = 2'd0; m_last_data = 32'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_we", write_enable, 1'b0);
    chk("rst_done", init_done, 1'b0);
    chk("rst_reg", write_register, 2'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_rdy0", request_ready_0, 1'b0);
    chk("rst_rdy1", request_ready_1, 1'b0);
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // One clock cycle: check readies for the driven inputs, then the write port after the edge.
  task automatic tick();
    bit          g0, g1, ew;
    logic [1:0]  ereg;
    logic [31:0] edata;
    #1;
    g0 = 0; g1 = 0;
    if (!m_init) begin
      if (request_valid_0 && request_valid_1) begin
        g0 = (m_pref == 0); g1 = (m_pref == 1);
      end else begin
        g0 = request_valid_0; g1 = request_valid_1;
      end
    end
    chk("ready_0", request_ready_0, g0);
    chk("ready_1", request_ready_1, g1);
    ew = 1; ereg = m_last_reg; edata = m_last_data;
    if (m_init) begin
      ereg = 2'(m_init_count); edata = 32'd0;
    end else if (g0) begin
      ereg = request_register_0; edata = request_data_0;
    end else if (g1) begin
      ereg = request_register_1; edata = request_data_1;
    end else begin
      ew = 0;
    end
    @(posedge clock);
    #1;
    chk("write_enable", write_enable, ew);
    chk("write_register", write_register, ereg);
    chk("write_data", write_data, edata);
    if (write_enable === 1'b1) dut_rf[write_register] = write_data;
    if (ew) begin
      exp_rf[ereg] = edata; m_last_reg = ereg; m_last_data = edata;
    end
    if (m_init) begin
      m_init_count++;
      if (m_init_count == 4) begin
        m_init = 0; m_done = 1;
      end
    end
    chk("init_done", init_done, m_done);
    if (g0) m_pref = 1;
    if (g1) m_pref = 0;
    acc0 = g0; acc1 = g1;
  endtask

  task automatic chk_rf_zero(input string tag);
    for (int i = 0; i < 4; i++) chk(tag, dut_rf[i], 32'd0);
  endtask

  initial begin
    request_valid_0 = 0; request_register_0 = 0; request_data_0 = 0;
    request_valid_1 = 0; request_register_1 = 0; request_data_1 = 0;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dut_rf[i] = 32'hBAD0_0000 + i; exp_rf[i] = 32'hBAD0_0000 + i;
    end
    #2;
    do_reset();

    // Initialisation with no requests.
    for (int i = 0; i < 4; i++) tick();
    chk_rf_zero("init_clear");
    tick();

    // Requester 0 alone, three back-to-back writes.
    request_valid_0 = 1; request_register_0 = 2'd1; request_data_0 = 32'hA5A5A5A5;
    tick();
    request_register_0 = 2'd2; request_data_0 = 32'h12345678;
    tick();
    request_register_0 = 2'd3; request_data_0 = 32'hFFFFFFFF;
    tick();
    request_valid_0 = 0;
    tick();
    chk("rf_r1", dut_rf[1], 32'hA5A5A5A5);
    chk("rf_r2", dut_rf[2], 32'h12345678);
    chk("rf_r3", dut_rf[3], 32'hFFFFFFFF);

    // Both requesters continuously valid, fresh data after each handshake.
    request_valid_0 = 1; request_register_0 = 2'd0; request_data_0 = $urandom;
    request_valid_1 = 1; request_register_1 = 2'd1; request_data_1 = $urandom;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (acc0) request_data_0 = $urandom;
      if (acc1) request_data_1 = $urandom;
    end
    request_valid_0 = 0; request_valid_1 = 0;
    tick();
    chk("alt_r0", dut_rf[0], exp_rf[0]);
    chk("alt_r1", dut_rf[1], exp_rf[1]);

    // Same target register; make requester 0 the preferred one first.
    if (m_pref == 1) begin
      request_valid_1 = 1; request_register_1 = 2'd0; request_data_1 = 32'h0;
      tick();
      request_valid_1 = 0;
    end
    request_valid_0 = 1; request_register_0 = 2'd2; request_data_0 = 32'h11111111;
    request_valid_1 = 1; request_register_1 = 2'd2; request_data_1 = 32'h22222222;
    tick();
    chk("same_first_r2", dut_rf[2], 32'h11111111);
    if (acc0) request_valid_0 = 0;
    tick();
    request_valid_0 = 0; request_valid_1 = 0;
    tick();
    chk("same_final_r2", dut_rf[2], 32'h22222222);

    // Randomized traffic obeying the requester hold rules.
    for (int i = 0; i < 300; i++) begin
      if (!request_valid_0 && $urandom_range(0, 99) < 60) begin
        request_valid_0 = 1; request_register_0 = 2'($urandom_range(0, 3)); request_data_0 = $urandom;
      end
      if (!request_valid_1 && $urandom_range(0, 99) < 60) begin
        request_valid_1 = 1; request_register_1 = 2'($urandom_range(0, 3)); request_data_1 = $urandom;
      end
      tick();
      if (acc0) request_valid_0 = 0;
      if (acc1) request_valid_1 = 0;
    end
    request_valid_0 = 0; request_valid_1 = 0;
    tick();
    for (int i = 0; i < 4; i++) chk("rand_rf", dut_rf[i], exp_rf[i]);

    // Reset mid-stream while a write is on the port, with requester 1 held into INIT.
    request_valid_0 = 1; request_register_0 = 2'd1; request_data_0 = 32'h5A5A0001;
    tick();
    chk("pre_rst_we", write_enable, 1'b1);
    request_valid_0 = 0;
    request_valid_1 = 1; request_register_1 = 2'd3; request_data_1 = 32'hDEADBEEF;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    chk_rf_zero("reinit_clear");
    tick();
    chk("init_req_accepted", acc1, 1'b1);
    request_valid_1 = 0;
    chk("init_req_r3", dut_rf[3], 32'hDEADBEEF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
